// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler that owns the HI/LO registers.
// The result is computed when the operation is issued and committed after a fixed latency.
module md_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_E,
  input  logic [2:0]  op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        stall_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] phi;
  logic [31:0] plo;
  logic        pwr;

  logic [63:0] prod;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic        div_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Division is done on magnitudes so that 0x80000000 / -1 wraps to 0x80000000
  // instead of overflowing a signed divider.
  always_comb begin
    // NOTE: every signal driven here is given a value on every path, so no latch is inferred.
    prod       = 64'd0;
    div_signed = (op_E == OP_DIV);
    a_neg      = div_signed & rs_E[31];
    b_neg      = div_signed & rt_E[31];
    div_zero   = (rt_E == 32'd0);
    a_mag      = a_neg ? (~rs_E + 32'd1) : rs_E;
    b_mag      = b_neg ? (~rt_E + 32'd1) : rt_E;
    b_safe     = div_zero ? 32'd1 : b_mag;
    q_mag      = a_mag / b_safe;
    r_mag      = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem        = a_neg ? (32'd0 - r_mag) : r_mag;
    if (op_E == OP_MULT) begin
      prod = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
    end else begin
      prod = {32'd0, rs_E} * {32'd0, rt_E};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      pwr   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      case (state)
        IDLE: begin
          if (start_E) begin
            case (op_E)
              OP_MULT, OP_MULTU: begin
                state      <= MUL;
                cnt        <= MUL_CYCLES;
                {phi, plo} <= prod;
                pwr        <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                state <= DIV;
                cnt   <= DIV_CYCLES;
                phi   <= rem;
                plo   <= quot;
                pwr   <= ~div_zero;
              end
              OP_MTHI: hi <= rs_E;
              OP_MTLO: lo <= rs_E;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          // A start_E arriving here is ignored; the operation in flight runs to completion.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= IDLE;
            if (pwr) begin
              hi <= phi;
              lo <= plo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign stall_D = md_use_D & (busy | start_E);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: randomized scoreboard bench for md_sched with a cycle-level reference model.
// Stimulus pushes expected HI/LO into a queue; a monitor pops on each DUT completion.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_E;
  logic [2:0]  op_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        md_use_D;
  logic        stall_D;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sched dut (
    .clk      (clk),
    .reset    (reset),
    .start_E  (start_E),
    .op_E     (op_E),
    .rs_E     (rs_E),
    .rt_E     (rt_E),
    .md_use_D (md_use_D),
    .stall_D  (stall_D),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  int          illegal_sent = 0;
  int          illegal_seen = 0;
  logic [31:0] ref_hi = 32'd0;
  logic [31:0] ref_lo = 32'd0;
  bit          rand_use = 1'b0;

  // monitor-side model state
  int          left = 0;
  bit          mt_pend = 1'b0;
  bit          prev_busy = 1'b0;
  bit          exp_busy;
  exp_t        mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from 64-bit integer arithmetic.
  function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l);
    exp_t            e;
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    e.hi = h;
    e.lo = l;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: {e.hi, e.lo} = sa * sb;
      3'd1: {e.hi, e.lo} = ua * ub;
      3'd2: if (b != 32'd0) begin
        e.lo = 32'(sa / sb);
        e.hi = 32'(sa % sb);
      end
      3'd3: if (b != 32'd0) begin
        e.lo = 32'(ua / ub);
        e.hi = 32'(ua % ub);
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_use) md_use_D = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("wait_idle_busy", busy, 1'b0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    wait_idle();
    e = ref_op(op, a, b, ref_hi, ref_lo);
    if (op <= 3'd5) begin
      sb_q.push_back(e);
      ref_hi = e.hi;
      ref_lo = e.lo;
    end
    start_E = 1'b1;
    op_E    = op;
    rs_E    = a;
    rt_E    = b;
    tick();
    start_E = 1'b0;
    op_E    = 3'($urandom);
    rs_E    = $urandom;
    rt_E    = $urandom;
  endtask

  task automatic inject_illegal();
    if (busy) begin
      start_E = 1'b1;
      op_E    = 3'($urandom);
      rs_E    = $urandom;
      rt_E    = $urandom;
      illegal_sent++;
      tick();
      start_E = 1'b0;
    end
  endtask

  // Monitor: per-cycle busy/stall model plus scoreboard pop on every HI/LO update.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("stall_in_reset", stall_D, md_use_D & start_E);
        check("busy_in_reset", busy, 1'b0);
        check("hi_in_reset", hi, 32'd0);
        check("lo_in_reset", lo, 32'd0);
        left      = 0;
        mt_pend   = 1'b0;
        prev_busy = 1'b0;
      end else begin
        exp_busy = (left > 0);
        check("busy", busy, exp_busy);
        check("stall_D", stall_D, md_use_D & (exp_busy | start_E));
        if ((prev_busy && !busy) || mt_pend) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL result: unexpected update hi=0x%0h lo=0x%0h at %0t", hi, lo, $time);
          end else begin
            mon_e = sb_q.pop_front();
            check("hi", hi, mon_e.hi);
            check("lo", lo, mon_e.lo);
          end
        end
        prev_busy = busy;
        mt_pend   = 1'b0;
        if (left > 0) begin
          if (start_E) illegal_seen++;
          left--;
        end else if (start_E) begin
          case (op_E)
            3'd0, 3'd1: left = 5;
            3'd2, 3'd3: left = 10;
            3'd4, 3'd5: mt_pend = 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] op;
    reset    = 1'b0;
    start_E  = 1'b0;
    op_E     = 3'd0;
    rs_E     = 32'd0;
    rt_E     = 32'd0;
    md_use_D = 1'b0;
    repeat (2) tick();
    // start_E during reset must be ignored while stall_D still follows it
    start_E  = 1'b1;
    md_use_D = 1'b1;
    rs_E     = 32'h1234_5678;
    rt_E     = 32'd9;
    tick();
    start_E  = 1'b0;
    md_use_D = 1'b0;
    reset    = 1'b1;

    // first edge after release already accepts an operation
    issue(3'd4, 32'h11, $urandom);
    issue(3'd5, 32'h22, $urandom);
    issue(3'd3, 32'd7, 32'd0);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    issue(3'd6, 32'h5555_5555, 32'd1);
    issue(3'd7, 32'hAAAA_AAAA, 32'd2);

    // md_use_D held through a mult: stalls while busy, released in the first idle cycle
    wait_idle();
    md_use_D = 1'b1;
    issue(3'd0, 32'd6, 32'd7);
    repeat (6) tick();
    md_use_D = 1'b0;

    // start while busy is ignored; in-flight result must be unaffected
    issue(3'd1, 32'h0001_0000, 32'h0001_0000);
    repeat (2) tick();
    inject_illegal();
    issue(3'd2, 32'd1000, 32'd33);
    inject_illegal();

    // reset in busy cycle 4 of a div aborts it
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    sb_q.delete();
    ref_hi = 32'd0;
    ref_lo = 32'd0;
    #1;
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_hi", hi, 32'd0);
    check("rst_async_lo", lo, 32'd0);
    tick();
    tick();
    reset = 1'b1;
    repeat (12) tick();
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);

    rand_use = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, pick(), pick());
      if (op <= 3'd3 && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 4)) tick();
        inject_illegal();
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    wait_idle();
    repeat (3) tick();
    check("scoreboard_drained", sb_q.size(), 0);
    check("illegal_start_flagged", illegal_seen, illegal_sent);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
